// File: rtl/fp16_mac_arbiter_if.sv
// Requester-side bus of the shared MAC arbiter: packed per-requester operands,
// one-hot grant and one-hot response strobe with a shared result word.
interface fp16_mac_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [8*NUM_REQ-1:0]  req_a;
  logic [8*NUM_REQ-1:0]  req_b;
  logic [16*NUM_REQ-1:0] req_c;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_c,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_c,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fp16_mac_arbiter.sv
// Round-robin arbiter sharing one FP8*FP8+FP16 MAC among NUM_REQ requesters; a tag
// pipe matched to the MAC depth steers each FP32 result back to its issuer.
module fp16_mac_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAC_LATENCY = 3,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arb_en,
  fp16_mac_arbiter_if.slave io_req,
  output logic              o_mac_valid,
  output logic [7:0]        o_mac_a,
  output logic [7:0]        o_mac_b,
  output logic [15:0]       o_mac_c,
  input  logic              i_mac_out_valid,
  input  logic [31:0]       i_mac_data_out,
  output logic              o_busy,
  output logic              o_err
);

  logic [NUM_REQ-1:0]     w_grant;
  logic [IDW-1:0]         w_gnt_id;
  logic                   w_accept;
  logic [IDW:0]           w_scan;

  logic [IDW-1:0]         r_ptr;
  logic                   r_mac_valid;
  logic [7:0]             r_mac_a;
  logic [7:0]             r_mac_b;
  logic [15:0]            r_mac_c;
  logic [IDW-1:0]         r_mac_id;

  logic [MAC_LATENCY-1:0] r_tag_vld_p;
  logic [IDW-1:0]         r_tag_id_p [MAC_LATENCY];

  logic                   w_tag_out_vld;
  logic [IDW-1:0]         w_tag_out_id;
  logic                   w_rsp_hit;
  logic                   w_mismatch;

  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [31:0]            r_rsp_data;
  logic                   r_err;

  // Scan from the requester after the last winner, wrapping, and take the first valid one.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_accept = 1'b0;
    w_scan   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_scan >= (IDW+1)'(NUM_REQ)) begin
        w_scan = w_scan - (IDW+1)'(NUM_REQ);
      end
      if (!w_accept && io_req.req_valid[w_scan[IDW-1:0]]) begin
        w_accept = 1'b1;
        w_gnt_id = w_scan[IDW-1:0];
      end
    end
    if (!i_arb_en || rst) begin
      w_accept = 1'b0;
      w_gnt_id = '0;
    end
    if (w_accept) begin
      w_grant = NUM_REQ'(1) << w_gnt_id;
    end
  end

  // Issue stage: granted operands go to the MAC, pointer moves to the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= IDW'(NUM_REQ - 1);
      r_mac_valid <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_c     <= '0;
      r_mac_id    <= '0;
    end else begin
      r_mac_valid <= w_accept;
      if (w_accept) begin
        r_ptr    <= w_gnt_id;
        r_mac_id <= w_gnt_id;
        r_mac_a  <= io_req.req_a[int'(w_gnt_id)*8 +: 8];
        r_mac_b  <= io_req.req_b[int'(w_gnt_id)*8 +: 8];
        r_mac_c  <= io_req.req_c[int'(w_gnt_id)*16 +: 16];
      end
    end
  end

  // Tag stages: stage 0 loads on the edge the MAC samples its input, then shifts freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld_p <= '0;
      for (int i = 0; i < MAC_LATENCY; i++) begin
        r_tag_id_p[i] <= '0;
      end
    end else begin
      r_tag_vld_p[0] <= r_mac_valid;
      r_tag_id_p[0]  <= r_mac_id;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        r_tag_vld_p[i] <= r_tag_vld_p[i-1];
        r_tag_id_p[i]  <= r_tag_id_p[i-1];
      end
    end
  end

  assign w_tag_out_vld = r_tag_vld_p[MAC_LATENCY-1];
  assign w_tag_out_id  = r_tag_id_p[MAC_LATENCY-1];
  assign w_rsp_hit     = w_tag_out_vld & i_mac_out_valid;
  assign w_mismatch    = w_tag_out_vld ^ i_mac_out_valid;

  // Response stage: a result is delivered only when tag and MAC agree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_hit ? (NUM_REQ'(1) << w_tag_out_id) : '0;
      if (w_rsp_hit) begin
        r_rsp_data <= i_mac_data_out;
      end
      if (w_mismatch) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_req.req_ready = w_grant;
  assign io_req.rsp_valid = r_rsp_valid;
  assign io_req.rsp_data  = r_rsp_data;
  assign o_mac_valid      = r_mac_valid;
  assign o_mac_a          = r_mac_a;
  assign o_mac_b          = r_mac_b;
  assign o_mac_c          = r_mac_c;
  assign o_busy           = r_mac_valid | (|r_tag_vld_p);
  assign o_err            = r_err;

endmodule
